// File: rtl/ram_8.sv
// ---------------------------------------------------------------------------
// ram_8 -- word-addressed single-port data memory (top of the Hack memory
// hierarchy: register -> RAM8 -> ... -> RAM16K).
//
// Reads are combinational: out follows address in the same cycle.
// Writes are synchronous: mem[address] <= val on the rising clk edge when
// load is high.
//
// An asynchronous reset must make the whole memory read as zero at once.
// A data array cannot be cleared in a single step, so each word carries a
// valid bit. Reset clears every valid bit. A word whose valid bit is clear
// reads as zero, whatever its storage holds.
//
// Optional build macro:
//   RAM_REGOUT_EN  Registers the read port. out <= mem[address] on every
//                  rising edge, giving one cycle of read latency. On a
//                  same-address write the register captures the pre-write
//                  word. rst_n low clears the register asynchronously.
//                  Write behaviour is the same in both builds.
//
// Parameters:
//   DATA_W   word width in bits (default 16)
//   ADDR_W   address width; depth = 2**ADDR_W words (default 14 -> 16K)
//
// Ports:
//   clk      system clock; all writes happen on its rising edge
//   rst_n    asynchronous active-low reset
//   val      write data
//   load     write enable, sampled on the rising edge of clk
//   address  word address, shared by the read and write paths
//   out      contents of the addressed word
// ---------------------------------------------------------------------------
module ram_8 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] val,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  word_vld;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    // A write needs reset released and load high. An unknown load does not
    // satisfy the if-conditions below, so it behaves as no write.
    assign wr_en = rst_n & load;

    // Per-word valid bits. This is the only state that reset touches.
    // Clearing it makes every word read as zero immediately, and it keeps
    // reset asserted in the middle of a write from leaving a stale word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_vld <= '0;
        end else if (wr_en) begin
            word_vld[address] <= 1'b1;
        end
    end

    // Data storage. It has no reset, so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[address] <= val;
        end
    end

    // Read path. Words that have not been written since reset read as zero.
    // There is no bypass from val: a same-cycle write shows up only after
    // the edge.
    always_comb begin
        rd_word = '0;
        if (word_vld[address]) begin
            rd_word = mem[address];
        end
    end

`ifdef RAM_REGOUT_EN
    logic [DATA_W-1:0] out_p1;

    // Registered read stage. mem is updated non-blocking, so a write to the
    // same address on this edge is not yet visible and the old word is
    // captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
        end else begin
            out_p1 <= rd_word;
        end
    end

    assign out = out_p1;
`else
    assign out = rd_word;
`endif

endmodule

// File: tb/tb_ram_8.sv
// ---------------------------------------------------------------------------
// tb_ram_8 -- scoreboard bench for ram_8.
//
// Each cycle, the driver applies inputs just after the rising edge. It then
// pushes the word the memory must present for that cycle, taken from a
// plain array model (contents before this cycle's write). After that it
// applies the write to the model.
//
// A monitor samples out on every falling edge and pops one expectation per
// cycle. With RAM_REGOUT_EN the monitor lags one entry behind, because the
// registered read shows the value one clock later.
// ---------------------------------------------------------------------------
module tb_ram_8;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 2 ** ADDR_W;
`ifdef RAM_REGOUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] val;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] out;

    logic [DATA_W-1:0] model [DEPTH];
    exp_t              exp_q [$];
    int                tests;
    int                fails;

    ram_8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .val     (val),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // One clock cycle. Inputs are driven #1 after a rising edge. On return
    // the time is #1 after the next rising edge.
    task automatic cycle(input logic ld, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] v);
        exp_t e;
        load    = ld;
        address = a;
        val     = v;
        e.data  = model[a];
        e.addr  = a;
        exp_q.push_back(e);
        if (ld) model[a] = v;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare out against the scoreboard on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > LAT) begin
                e = exp_q.pop_front();
                check($sformatf("read@%0d", e.addr), out, e.data);
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
        $fatal(1, "timeout");
    end

    logic [ADDR_W-1:0] hot [8];

    initial begin
        tests   = 0;
        fails   = 0;
        load    = 1'b0;
        val     = '0;
        address = 14'd4739;
        rst_n   = 1'b0;
        model_clear();

        // 1. Reset: out is zero while rst_n is low, and after release.
        #3;
        check("reset_out", out, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", out, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("reset_release", out, 16'h0000);
        cycle(1'b0, 14'd4739, 16'h0000);

        // 2. Write two words and read them back.
        cycle(1'b1, 14'd4739, 16'd3);
        cycle(1'b1, 14'd10861, 16'd15);
        cycle(1'b0, 14'd4739, 16'h0000);
        cycle(1'b0, 14'd10861, 16'h0000);

        // 3. load=0 blocks writes.
        repeat (3) cycle(1'b0, 14'd4739, 16'hFFFF);
        cycle(1'b0, 14'd4739, 16'h0000);

        // 4. Boundary addresses, and a check for aliasing.
        cycle(1'b1, 14'd0, 16'hAAAA);
        cycle(1'b1, 14'd16383, 16'h5555);
        cycle(1'b0, 14'd0, 16'h0000);
        cycle(1'b0, 14'd16383, 16'h0000);
        cycle(1'b0, 14'd1, 16'h0000);
        cycle(1'b0, 14'd16382, 16'h0000);

        // 5. Read during write at the same address: old value, then new.
        cycle(1'b1, 14'd10861, 16'h1234);
        cycle(1'b0, 14'd10861, 16'h0000);
        cycle(1'b0, 14'd10861, 16'h0000);

        // Randomized traffic. Most cycles use a small hot set of addresses
        // so that writes are read back often.
        hot[0] = 14'd0;     hot[1] = 14'd16383; hot[2] = 14'd4739;
        hot[3] = 14'd10861; hot[4] = 14'd1;     hot[5] = 14'd16382;
        hot[6] = 14'd8192;  hot[7] = 14'd8191;
        for (int n = 0; n < 300; n++) begin
            logic [ADDR_W-1:0] a;
            logic              ld;
            if ($urandom_range(3) == 0) a = ADDR_W'($urandom_range(DEPTH - 1));
            else                        a = hot[$urandom_range(7)];
            ld = ($urandom_range(2) == 0);
            cycle(ld, a, DATA_W'($urandom));
        end
        cycle(1'b0, 14'd4739, 16'h0000);
        cycle(1'b0, 14'd10861, 16'h0000);

        // 6. Reset asserted asynchronously between edges while a write is
        //    pending. The write is lost and every word reads zero.
        load    = 1'b1;
        address = 14'd10861;
        val     = 16'hBEEF;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, 16'h0000);
        exp_q.delete();
        model_clear();
        load = 1'b0;
        address = 14'd4739;  #1; check("rst_rd_4739", out, 16'h0000);
        address = 14'd10861; #1; check("rst_rd_10861", out, 16'h0000);
        address = 14'd0;     #1; check("rst_rd_0", out, 16'h0000);
        address = 14'd16383; #1; check("rst_rd_16383", out, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_rd_edge", out, 16'h0000);
        rst_n = 1'b1;
        cycle(1'b0, 14'd4739, 16'h0000);
        cycle(1'b0, 14'd10861, 16'h0000);
        cycle(1'b0, 14'd0, 16'h0000);
        cycle(1'b0, 14'd16383, 16'h0000);

        // 7. Scenario 2 again after reset. The scoreboard applies the read
        //    latency of the build.
        cycle(1'b1, 14'd4739, 16'd3);
        cycle(1'b1, 14'd10861, 16'd15);
        cycle(1'b0, 14'd4739, 16'h0000);
        cycle(1'b0, 14'd10861, 16'h0000);
        cycle(1'b0, 14'd10861, 16'h0000);
        cycle(1'b0, 14'd10861, 16'h0000);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
